// File: rtl/ahbl_arbiter_if.sv
// AHB-lite N:1 arbiter bus bundle: per-master upstream signals plus the single downstream port.
// The slave modport is the arbiter's view; master is the complementary view.
interface ahbl_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
);
    logic [N_PORTS-1:0]        src_hready;
    logic [N_PORTS-1:0]        src_hready_resp;
    logic [N_PORTS-1:0]        src_hresp;
    logic [N_PORTS*W_ADDR-1:0] src_haddr;
    logic [N_PORTS-1:0]        src_hwrite;
    logic [N_PORTS*2-1:0]      src_htrans;
    logic [N_PORTS*3-1:0]      src_hsize;
    logic [N_PORTS*3-1:0]      src_hburst;
    logic [N_PORTS*4-1:0]      src_hprot;
    logic [N_PORTS-1:0]        src_hmastlock;
    logic [N_PORTS*W_DATA-1:0] src_hwdata;
    logic [N_PORTS*W_DATA-1:0] src_hrdata;

    logic                      dst_hready;
    logic                      dst_hready_resp;
    logic                      dst_hresp;
    logic [W_ADDR-1:0]         dst_haddr;
    logic                      dst_hwrite;
    logic [1:0]                dst_htrans;
    logic [2:0]                dst_hsize;
    logic [2:0]                dst_hburst;
    logic [3:0]                dst_hprot;
    logic                      dst_hmastlock;
    logic [W_DATA-1:0]         dst_hwdata;
    logic [W_DATA-1:0]         dst_hrdata;

    modport slave (
        input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
               src_hprot, src_hmastlock, src_hwdata,
               dst_hready_resp, dst_hresp, dst_hrdata,
        output src_hready_resp, src_hresp, src_hrdata,
               dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
               dst_hprot, dst_hmastlock, dst_hwdata
    );

    modport master (
        output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
               src_hprot, src_hmastlock, src_hwdata,
               dst_hready_resp, dst_hresp, dst_hrdata,
        input  src_hready_resp, src_hresp, src_hrdata,
               dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
               dst_hprot, dst_hmastlock, dst_hwdata
    );
endinterface

// File: rtl/ahbl_arbiter.sv
// AHB-lite N:1 fixed-priority arbiter (lowest index wins). Losing or stalled address
// phases are parked in a per-port buffer and the master is held in its data phase.
module ahbl_arbiter #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input logic          clk,
    input logic          rst_n,
    ahbl_arbiter_if.slave bus
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    typedef struct packed {
        logic [W_ADDR-1:0] haddr;
        logic              hwrite;
        logic [1:0]        htrans;
        logic [2:0]        hsize;
        logic [2:0]        hburst;
        logic [3:0]        hprot;
        logic              hmastlock;
    } addr_phase_t;

    logic [N_PORTS-1:0] live_req;
    logic [N_PORTS-1:0] req;
    logic [N_PORTS-1:0] grant_a;
    logic [N_PORTS-1:0] buf_load;
    logic [N_PORTS-1:0] buf_valid_q, buf_valid_d;
    logic [N_PORTS-1:0] grant_d_q, grant_d_d;
    addr_phase_t        live_ap  [N_PORTS];
    addr_phase_t        buf_ap_q [N_PORTS];
    addr_phase_t        dst_ap;

    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        live_req = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            live_ap[i].haddr     = bus.src_haddr[i*W_ADDR +: W_ADDR];
            live_ap[i].hwrite    = bus.src_hwrite[i];
            live_ap[i].htrans    = bus.src_htrans[i*2 +: 2];
            live_ap[i].hsize     = bus.src_hsize[i*3 +: 3];
            live_ap[i].hburst    = bus.src_hburst[i*3 +: 3];
            live_ap[i].hprot     = bus.src_hprot[i*4 +: 4];
            live_ap[i].hmastlock = bus.src_hmastlock[i];
            live_req[i]          = bus.src_hready[i] && (live_ap[i].htrans != HTRANS_IDLE);
        end
    end

    assign req = buf_valid_q | live_req;

    always_comb begin
        grant_a = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (req[i] && (grant_a == '0)) grant_a[i] = 1'b1;
        end
    end

    // An all-zero dst_ap drives HTRANS = IDLE when nobody is granted.
    always_comb begin
        dst_ap = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_a[i]) dst_ap = buf_valid_q[i] ? buf_ap_q[i] : live_ap[i];
        end
    end

    assign bus.dst_haddr     = dst_ap.haddr;
    assign bus.dst_hwrite    = dst_ap.hwrite;
    assign bus.dst_htrans    = dst_ap.htrans;
    assign bus.dst_hsize     = dst_ap.hsize;
    assign bus.dst_hburst    = dst_ap.hburst;
    assign bus.dst_hprot     = dst_ap.hprot;
    assign bus.dst_hmastlock = dst_ap.hmastlock;
    assign bus.dst_hready    = bus.dst_hready_resp;

    // A live phase is parked unless it is granted on a ready cycle (lost or downstream stalled).
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_load    = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_a[i] && bus.dst_hready_resp) begin
                buf_valid_d[i] = 1'b0;
            end else if (live_req[i] && !buf_valid_q[i]) begin
                buf_valid_d[i] = 1'b1;
                buf_load[i]    = 1'b1;
            end
        end
    end

    assign grant_d_d = bus.dst_hready_resp ? grant_a : grant_d_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= '0;
            grant_d_q   <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            grant_d_q   <= grant_d_d;
        end
    end

    // NOTE: the buffered payload is not reset; buf_valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PORTS; i++) begin
            if (buf_load[i]) buf_ap_q[i] <= live_ap[i];
        end
    end

    always_comb begin
        bus.dst_hwdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_d_q[i]) bus.dst_hwdata = bus.src_hwdata[i*W_DATA +: W_DATA];
        end
    end

    // Ready depends only on registered state and downstream ready, never on src_htrans.
    always_comb begin
        bus.src_hready_resp = '1;
        bus.src_hresp       = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (buf_valid_q[i])    bus.src_hready_resp[i] = 1'b0;
            else if (grant_d_q[i]) bus.src_hready_resp[i] = bus.dst_hready_resp;
            bus.src_hresp[i] = grant_d_q[i] && bus.dst_hresp;
        end
    end

    assign bus.src_hrdata = {N_PORTS{bus.dst_hrdata}};

endmodule

// File: tb/tb_ahbl_arbiter.sv
// Directed bench for ahbl_arbiter: an index-based reference model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_ahbl_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int APW = AW + 14;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    logic clk = 1'b0;
    logic rst_n;

    ahbl_arbiter_if #(.N_PORTS(N), .W_ADDR(AW), .W_DATA(DW)) bus ();

    ahbl_arbiter #(.N_PORTS(N), .W_ADDR(AW), .W_DATA(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Masters are true AHB masters: their HREADY is the arbiter's HREADYOUT.
    assign bus.src_hready = bus.src_hready_resp;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit               m_pend [N] = '{default: 1'b0};
    logic [APW-1:0]   m_ap   [N];
    int               m_owner = -1;
    bit               n_pend [N] = '{default: 1'b0};
    logic [APW-1:0]   n_ap   [N];
    int               n_owner = -1;

    function automatic logic [APW-1:0] live_ap(input int p);
        return {bus.src_haddr[p*AW +: AW], bus.src_hwrite[p], bus.src_htrans[p*2 +: 2],
                bus.src_hsize[p*3 +: 3], bus.src_hburst[p*3 +: 3], bus.src_hprot[p*4 +: 4],
                bus.src_hmastlock[p]};
    endfunction

    initial begin : model_compare
        logic [N-1:0]   exp_rdy;
        logic [N-1:0]   exp_resp;
        bit             live [N];
        int             win;
        logic [DW-1:0]  exp_wd;
        forever begin
            @(negedge clk);
            for (int p = 0; p < N; p++) begin
                exp_rdy[p]  = m_pend[p] ? 1'b0 : (m_owner == p ? bus.dst_hready_resp : 1'b1);
                exp_resp[p] = (m_owner == p) && bus.dst_hresp;
                live[p]     = exp_rdy[p] && (bus.src_htrans[p*2 +: 2] != IDLE);
            end
            win = -1;
            for (int p = 0; p < N; p++) if (win < 0 && (m_pend[p] || live[p])) win = p;
            exp_wd = (m_owner < 0) ? '0 : bus.src_hwdata[m_owner*DW +: DW];

            check("m_hready_resp", bus.src_hready_resp, exp_rdy);
            check("m_hresp", bus.src_hresp, exp_resp);
            check("m_hwdata", bus.dst_hwdata, exp_wd);
            check("m_dst_hready", bus.dst_hready, bus.dst_hready_resp);
            check("m_hrdata", bus.src_hrdata, {bus.dst_hrdata, bus.dst_hrdata});
            if (win < 0)
                check("m_htrans_idle", bus.dst_htrans, IDLE);
            else
                check("m_addr_phase",
                      {bus.dst_haddr, bus.dst_hwrite, bus.dst_htrans, bus.dst_hsize,
                       bus.dst_hburst, bus.dst_hprot, bus.dst_hmastlock},
                      m_pend[win] ? m_ap[win] : live_ap(win));

            n_owner = bus.dst_hready_resp ? win : m_owner;
            for (int p = 0; p < N; p++) begin
                n_pend[p] = m_pend[p];
                n_ap[p]   = m_ap[p];
                if (win == p && bus.dst_hready_resp) begin
                    n_pend[p] = 1'b0;
                end else if (live[p]) begin
                    n_pend[p] = 1'b1;
                    n_ap[p]   = live_ap(p);
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  <= '{default: 1'b0};
            m_owner <= -1;
        end else begin
            m_pend  <= n_pend;
            m_ap    <= n_ap;
            m_owner <= n_owner;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int p, input logic [1:0] tr, input logic [31:0] a, input logic wr);
        bus.src_htrans[p*2 +: 2]   = tr;
        bus.src_haddr[p*AW +: AW]  = a;
        bus.src_hwrite[p]          = wr;
        bus.src_hsize[p*3 +: 3]    = 3'b010;
        bus.src_hburst[p*3 +: 3]   = 3'b000;
        bus.src_hprot[p*4 +: 4]    = 4'b0011;
        bus.src_hmastlock[p]       = 1'b0;
    endtask

    task automatic wdata(input int p, input logic [31:0] d);
        bus.src_hwdata[p*DW +: DW] = d;
    endtask

    task automatic slave(input logic rdy, input logic rsp, input logic [31:0] rd);
        bus.dst_hready_resp = rdy;
        bus.dst_hresp       = rsp;
        bus.dst_hrdata      = rd;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst_n = 1'b0;
        for (int p = 0; p < N; p++) begin
            drive(p, IDLE, '0, 1'b0);
            wdata(p, '0);
        end
        slave(1'b1, 1'b0, '0);
        wdata(0, 32'h0BAD_0000);
        #2;
        check("rst_htrans", bus.dst_htrans, IDLE);
        check("rst_hready_resp", bus.src_hready_resp, 2'b11);
        check("rst_hresp", bus.src_hresp, 2'b00);
        check("rst_hwdata", bus.dst_hwdata, 32'h0);
        cyc(); cyc();
        #2 rst_n = 1'b1;

        // Single master write, zero added latency.
        cyc(); drive(0, NONSEQ, 32'h100, 1'b1); #1;
        check("single_htrans", bus.dst_htrans, NONSEQ);
        check("single_haddr", bus.dst_haddr, 32'h100);
        check("single_hwrite", bus.dst_hwrite, 1'b1);
        cyc(); drive(0, IDLE, '0, 1'b0); wdata(0, 32'hDEAD_BEEF); wdata(1, 32'h1111_1111); #1;
        check("single_hwdata", bus.dst_hwdata, 32'hDEAD_BEEF);
        check("single_ready", bus.src_hready_resp, 2'b11);

        // Collision: port 0 wins, port 1 is buffered and issued next cycle.
        cyc(); drive(0, NONSEQ, 32'h10, 1'b0); drive(1, NONSEQ, 32'h20, 1'b0); #1;
        check("coll_haddr0", bus.dst_haddr, 32'h10);
        check("coll_ready0", bus.src_hready_resp, 2'b11);
        cyc(); drive(0, IDLE, '0, 1'b0); drive(1, IDLE, '0, 1'b0); slave(1'b1, 1'b0, 32'hCAFE_0010); #1;
        check("coll_haddr1", bus.dst_haddr, 32'h20);
        check("coll_htrans1", bus.dst_htrans, NONSEQ);
        check("coll_stall1", bus.src_hready_resp, 2'b01);
        check("coll_rdata0", bus.src_hrdata[31:0], 32'hCAFE_0010);
        cyc(); slave(1'b1, 1'b0, 32'hCAFE_0020); #1;
        check("coll_ready1", bus.src_hready_resp, 2'b11);
        check("coll_rdata1", bus.src_hrdata[63:32], 32'hCAFE_0020);
        check("coll_idle", bus.dst_htrans, IDLE);

        // Downstream stall for three cycles while port 1 requests.
        cyc(); slave(1'b0, 1'b0, '0); drive(1, NONSEQ, 32'h30, 1'b1); #1;
        check("stall_live_addr", bus.dst_haddr, 32'h30);
        check("stall_live_ready", bus.src_hready_resp, 2'b11);
        cyc(); drive(1, IDLE, '0, 1'b0); wdata(1, 32'h3030_3030); #1;
        check("stall_buf_htrans", bus.dst_htrans, NONSEQ);
        check("stall_buf_addr", bus.dst_haddr, 32'h30);
        check("stall_buf_ready", bus.src_hready_resp, 2'b01);
        cyc(); #1;
        check("stall_hold_htrans", bus.dst_htrans, NONSEQ);
        check("stall_hold_ready", bus.src_hready_resp, 2'b01);
        cyc(); slave(1'b1, 1'b0, '0); #1;
        check("stall_issue_addr", bus.dst_haddr, 32'h30);
        check("stall_issue_write", bus.dst_hwrite, 1'b1);
        cyc(); #1;
        check("stall_hwdata", bus.dst_hwdata, 32'h3030_3030);
        check("stall_done_ready", bus.src_hready_resp, 2'b11);

        // Two-cycle error response on port 1.
        cyc(); drive(1, NONSEQ, 32'h40, 1'b0); #1;
        check("err_addr", bus.dst_haddr, 32'h40);
        cyc(); drive(1, IDLE, '0, 1'b0); slave(1'b0, 1'b1, '0); #1;
        check("err_resp1", bus.src_hresp, 2'b10);
        check("err_ready1", bus.src_hready_resp, 2'b01);
        cyc(); slave(1'b1, 1'b1, '0); #1;
        check("err_resp2", bus.src_hresp, 2'b10);
        check("err_ready2", bus.src_hready_resp, 2'b11);
        cyc(); slave(1'b1, 1'b0, '0); #1;
        check("err_clear", bus.src_hresp, 2'b00);

        // Port 0 back-to-back NONSEQs, port 1 idle.
        wdata(1, 32'h5555_5555);
        for (int k = 0; k < 4; k++) begin
            cyc(); drive(0, NONSEQ, 32'h200 + 32'(4 * k), 1'b1); wdata(0, 32'hA000_0000 | 32'(k)); #1;
            check("b2b_haddr", bus.dst_haddr, 32'h200 + 32'(4 * k));
            check("b2b_ready", bus.src_hready_resp, 2'b11);
            if (k > 0) check("b2b_hwdata", bus.dst_hwdata, 32'hA000_0000 | 32'(k));
        end
        cyc(); drive(0, IDLE, '0, 1'b0); wdata(0, 32'hA000_0004); #1;
        check("b2b_last_hwdata", bus.dst_hwdata, 32'hA000_0004);

        // Reset while port 1 is buffered.
        cyc(); drive(0, NONSEQ, 32'h50, 1'b0); drive(1, NONSEQ, 32'h60, 1'b0); #1;
        cyc(); drive(0, IDLE, '0, 1'b0); drive(1, IDLE, '0, 1'b0); #1;
        check("rstmid_buffered", bus.src_hready_resp, 2'b01);
        check("rstmid_haddr", bus.dst_haddr, 32'h60);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_htrans", bus.dst_htrans, IDLE);
        check("rstmid_ready", bus.src_hready_resp, 2'b11);
        check("rstmid_hresp", bus.src_hresp, 2'b00);
        check("rstmid_hwdata", bus.dst_hwdata, 32'h0);
        cyc(); cyc();
        #2 rst_n = 1'b1;
        cyc(); cyc(); #1;
        check("post_rst_htrans", bus.dst_htrans, IDLE);
        check("post_rst_ready", bus.src_hready_resp, 2'b11);
        cyc(); cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
